axis_video_checker: RTL and testbench

Passive, synthesizable AXI4-Stream video monitor that taps any video link in the keystone pipeline (input or output side of `Keystone`) without affecting it. It tracks pixel/line/frame position and checks SOF (`tuser`) and EOL (`tlast`) framing against the configured geometry. It compares each accepted pixel against a parametrised per-channel ramp pattern and exposes saturating counters plus sticky error flags for AXI-Lite readback or bench assertions. It generalises the team's fixed 1920-wide, 3-channel, 8-in-10-bit self-check into width, height, channel count and component packing.

---
 rtl/video_chk_pkg.sv | 27 ++
 rtl/video_pattern_acc.sv | 47 ++++
 rtl/axis_video_checker.sv | 238 +++++++++++++++++++++++
 tb/tb_axis_video_checker.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_chk_pkg.sv
// -----------------------------------------------------------------------------
// video_chk_pkg
// Shared types and constants for the AXI4-Stream video checker.
//   state_t      : frame-tracking state (waiting for SOF / inside a frame)
//   ERR_*        : bit positions inside err_flags
//   CNT_W        : width of the saturating event counters
//   POS_W        : width of the x/y position trackers and capture coordinates
// No ports (package).
// -----------------------------------------------------------------------------
package video_chk_pkg;

   typedef enum logic {
      ST_WAIT_SOF = 1'b0,
      ST_IN_FRAME = 1'b1
   } state_t;

   localparam int ERR_SOF_MISSING = 0;
   localparam int ERR_SOF_EARLY   = 1;
   localparam int ERR_EOL_EARLY   = 2;
   localparam int ERR_EOL_LATE    = 3;
   localparam int ERR_DATA        = 4;
   localparam int ERR_W           = 5;

   localparam int CNT_W = 32;
   localparam int POS_W = 16;

endpackage

// File: rtl/video_pattern_acc.sv
// -----------------------------------------------------------------------------
// video_pattern_acc
// Expected-value generator for one colour channel of the ramp pattern.
// The pixel that opens a frame expects the seed; every following accepted
// pixel expects the previous value plus a two's-complement step, wrapping
// modulo 2^COMP_W.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous clear of the accumulator (highest priority)
//   load        : current beat opens a frame, expected = seed
//   advance     : current beat is compared, accumulator moves one step
//   seed, step  : per-channel seed and signed increment
//   expected    : value the current beat must carry on this channel
// -----------------------------------------------------------------------------
module video_pattern_acc #(
   parameter int COMP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic              advance,
   input  logic [COMP_W-1:0] seed,
   input  logic [COMP_W-1:0] step,
   output logic [COMP_W-1:0] expected
);

   logic signed [COMP_W-1:0] acc;
   logic signed [COMP_W-1:0] base;
   logic signed [COMP_W-1:0] incr;

   assign base     = load ? signed'(seed) : acc;
   assign incr     = signed'(step);
   assign expected = base;

   // Same-width signed add: overflow simply wraps, which is the intended ramp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (load || advance) begin
         acc <= base + incr;
      end
   end

endmodule

// File: rtl/axis_video_checker.sv
// -----------------------------------------------------------------------------
// axis_video_checker
// Passive AXI4-Stream video monitor. Tracks x/y/frame position of accepted
// beats, checks SOF (tuser) and EOL (tlast) framing against WIDTH x HEIGHT,
// compares every in-frame pixel to a per-channel ramp and reports saturating
// counters plus sticky error flags. Never drives the monitored link.
//
// Optional build macro: VIDEO_CHK_CAPTURE_EN
//   defined   : first_err_* hold position/expected/actual of the first data
//               mismatch since reset or chk_clear
//   undefined : no capture registers; first_err_* read as zero
//
// Ports:
//   aclk, aresetn       : clock, asynchronous active-low reset
//   aclken              : clock enable, a beat only counts while high
//   axis_tdata/tvalid/tready/tuser/tlast : monitored stream
//   chk_clear           : synchronous clear of counters, flags and capture
//   pat_seed, pat_step  : per-channel ramp seed and two's-complement step
//   pixel_count         : accepted beats (saturating)
//   frame_count         : completed frames (saturating)
//   mismatch_count      : pixels with any channel off-pattern (saturating)
//   err_flags           : sticky {DATA, EOL_LATE, EOL_EARLY, SOF_EARLY, SOF_MISSING}
//   first_err_x/y/exp/act : first-mismatch capture
// -----------------------------------------------------------------------------
module axis_video_checker
   import video_chk_pkg::*;
#(
   parameter int WIDTH   = 1920,
   parameter int HEIGHT  = 1080,
   parameter int NUM_CH  = 3,
   parameter int COMP_W  = 8,
   parameter int SLOT_W  = 10,
   parameter int LSB_PAD = 2,
   parameter int DATA_W  = 64
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     aclken,
   input  logic [DATA_W-1:0]        axis_tdata,
   input  logic                     axis_tvalid,
   input  logic                     axis_tready,
   input  logic                     axis_tuser,
   input  logic                     axis_tlast,
   input  logic                     chk_clear,
   input  logic [NUM_CH*COMP_W-1:0] pat_seed,
   input  logic [NUM_CH*COMP_W-1:0] pat_step,
   output logic [31:0]              pixel_count,
   output logic [31:0]              frame_count,
   output logic [31:0]              mismatch_count,
   output logic [4:0]               err_flags,
   output logic [15:0]              first_err_x,
   output logic [15:0]              first_err_y,
   output logic [NUM_CH*COMP_W-1:0] first_err_exp,
   output logic [NUM_CH*COMP_W-1:0] first_err_act
);

   localparam int PAT_W = NUM_CH * COMP_W;
   localparam logic [POS_W-1:0] X_LAST = POS_W'(WIDTH - 1);
   localparam logic [POS_W-1:0] Y_LAST = POS_W'(HEIGHT - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
   endfunction

   state_t             state;
   state_t             state_next;
   logic [POS_W-1:0]   x;
   logic [POS_W-1:0]   y;
   logic [POS_W-1:0]   cur_x;
   logic [POS_W-1:0]   cur_y;
   logic               beat;
   logic               sof_beat;
   logic               do_compare;
   logic               at_last_x;
   logic               last_line;
   logic               wrap;
   logic               frame_done;
   logic               data_err;
   logic [ERR_W-1:0]   err_set;
   logic [PAT_W-1:0]   exp_vec;
   logic [PAT_W-1:0]   act_vec;
   logic [CNT_W-1:0]   pix_cnt;
   logic [CNT_W-1:0]   frm_cnt;
   logic [CNT_W-1:0]   mis_cnt;
   logic [ERR_W-1:0]   flags;
   logic               unused_tdata;

   // Padding/spare bits of tdata are deliberately ignored.
   assign unused_tdata = ^axis_tdata;

   assign beat       = aclken & axis_tvalid & axis_tready;
   assign sof_beat   = beat & axis_tuser;
   // A tuser beat is compared from either state: it opens or restarts a frame.
   assign do_compare = beat & (axis_tuser | (state == ST_IN_FRAME));
   assign data_err   = do_compare & (act_vec != exp_vec);

   // Per-channel component extraction and expected-value generation.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign act_vec[c*COMP_W +: COMP_W] = axis_tdata[c*SLOT_W+LSB_PAD +: COMP_W];

      video_pattern_acc #(
         .COMP_W (COMP_W)
      ) u_acc (
         .clk      (aclk),
         .rst_n    (aresetn),
         .clear    (chk_clear),
         .load     (sof_beat),
         .advance  (do_compare),
         .seed     (pat_seed[c*COMP_W +: COMP_W]),
         .step     (pat_step[c*COMP_W +: COMP_W]),
         .expected (exp_vec[c*COMP_W +: COMP_W])
      );
   end

   // ---- FSM: state register ----
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= ST_WAIT_SOF;
      end else begin
         state <= state_next;
      end
   end

   // ---- FSM: next state ----
   // A line wrap on the last line closes the frame, whether the wrap came from
   // the geometry or from an early tlast; only the former counts as a frame.
   always_comb begin
      state_next = state;
      if (chk_clear) begin
         state_next = ST_WAIT_SOF;
      end else if (do_compare) begin
         state_next = (wrap && last_line) ? ST_WAIT_SOF : ST_IN_FRAME;
      end
   end

   // ---- FSM: per-beat decode ----
   // SOF is resolved first, so a beat carrying tuser and tlast together is
   // checked for EOL at x=0.
   always_comb begin
      cur_x      = sof_beat ? '0 : x;
      cur_y      = sof_beat ? '0 : y;
      at_last_x  = (cur_x == X_LAST);
      last_line  = (cur_y == Y_LAST);
      wrap       = at_last_x | axis_tlast;
      frame_done = do_compare & at_last_x & last_line;
      err_set    = '0;
      err_set[ERR_SOF_MISSING] = beat & ~axis_tuser & (state == ST_WAIT_SOF);
      err_set[ERR_SOF_EARLY]   = sof_beat & (state == ST_IN_FRAME);
      err_set[ERR_EOL_EARLY]   = do_compare & axis_tlast & ~at_last_x;
      err_set[ERR_EOL_LATE]    = do_compare & at_last_x & ~axis_tlast;
      err_set[ERR_DATA]        = data_err;
   end

   // ---- position, counters and sticky flags ----
   // chk_clear acts even with aclken low and wins over a coincident beat.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x       <= '0;
         y       <= '0;
         pix_cnt <= '0;
         frm_cnt <= '0;
         mis_cnt <= '0;
         flags   <= '0;
      end else if (chk_clear) begin
         x       <= '0;
         y       <= '0;
         pix_cnt <= '0;
         frm_cnt <= '0;
         mis_cnt <= '0;
         flags   <= '0;
      end else if (beat) begin
         pix_cnt <= sat_inc(pix_cnt);
         flags   <= flags | err_set;
         if (do_compare) begin
            if (wrap) begin
               x <= '0;
               y <= last_line ? '0 : cur_y + POS_W'(1);
            end else begin
               x <= cur_x + POS_W'(1);
               y <= cur_y;
            end
         end
         if (frame_done) begin
            frm_cnt <= sat_inc(frm_cnt);
         end
         if (data_err) begin
            mis_cnt <= sat_inc(mis_cnt);
         end
      end
   end

   assign pixel_count    = pix_cnt;
   assign frame_count    = frm_cnt;
   assign mismatch_count = mis_cnt;
   assign err_flags      = flags;

`ifdef VIDEO_CHK_CAPTURE_EN
   logic             captured;
   logic [POS_W-1:0] cap_x;
   logic [POS_W-1:0] cap_y;
   logic [PAT_W-1:0] cap_exp;
   logic [PAT_W-1:0] cap_act;

   // ---- first-mismatch capture, held until reset or chk_clear ----
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         captured <= 1'b0;
         cap_x    <= '0;
         cap_y    <= '0;
         cap_exp  <= '0;
         cap_act  <= '0;
      end else if (chk_clear) begin
         captured <= 1'b0;
         cap_x    <= '0;
         cap_y    <= '0;
         cap_exp  <= '0;
         cap_act  <= '0;
      end else if (data_err && !captured) begin
         captured <= 1'b1;
         cap_x    <= cur_x;
         cap_y    <= cur_y;
         cap_exp  <= exp_vec;
         cap_act  <= act_vec;
      end
   end

   assign first_err_x   = cap_x;
   assign first_err_y   = cap_y;
   assign first_err_exp = cap_exp;
   assign first_err_act = cap_act;
`else
   assign first_err_x   = '0;
   assign first_err_y   = '0;
   assign first_err_exp = '0;
   assign first_err_act = '0;
`endif

endmodule

// File: tb/tb_axis_video_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_video_checker
// Self-checking bench for axis_video_checker (WIDTH=4, HEIGHT=2, 3 channels).
// A behavioural model derives every output from the frame rules: the expected
// pixel value is seed + k*step for the k-th pixel of the frame. Outputs are
// compared with the model on every falling edge, and directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_axis_video_checker;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int NC = 3;
   localparam int CW = 8;
   localparam int SW = 10;
   localparam int LP = 2;
   localparam int DW = 64;
   localparam int PW = NC * CW;

`ifdef VIDEO_CHK_CAPTURE_EN
   localparam bit CAP_ON = 1'b1;
`else
   localparam bit CAP_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          aresetn;
   logic          aclken;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tuser;
   logic          tlast;
   logic          chk_clear;
   logic [PW-1:0] pat_seed;
   logic [PW-1:0] pat_step;
   logic [31:0]   pixel_count;
   logic [31:0]   frame_count;
   logic [31:0]   mismatch_count;
   logic [4:0]    err_flags;
   logic [15:0]   first_err_x;
   logic [15:0]   first_err_y;
   logic [PW-1:0] first_err_exp;
   logic [PW-1:0] first_err_act;

   always #5 clk = ~clk;

   axis_video_checker #(
      .WIDTH   (W),
      .HEIGHT  (H),
      .NUM_CH  (NC),
      .COMP_W  (CW),
      .SLOT_W  (SW),
      .LSB_PAD (LP),
      .DATA_W  (DW)
   ) dut (
      .aclk           (clk),
      .aresetn        (aresetn),
      .aclken         (aclken),
      .axis_tdata     (tdata),
      .axis_tvalid    (tvalid),
      .axis_tready    (tready),
      .axis_tuser     (tuser),
      .axis_tlast     (tlast),
      .chk_clear      (chk_clear),
      .pat_seed       (pat_seed),
      .pat_step       (pat_step),
      .pixel_count    (pixel_count),
      .frame_count    (frame_count),
      .mismatch_count (mismatch_count),
      .err_flags      (err_flags),
      .first_err_x    (first_err_x),
      .first_err_y    (first_err_y),
      .first_err_exp  (first_err_exp),
      .first_err_act  (first_err_act)
   );

   int vectors     = 0;
   int miscompares = 0;

   // ---- behavioural model state ----
   bit            m_in_frame;
   int            m_k;
   int            m_x;
   int            m_y;
   logic [PW-1:0] m_seed;
   logic [31:0]   m_pix;
   logic [31:0]   m_frames;
   logic [31:0]   m_mism;
   logic [4:0]    m_flags;
   bit            m_capv;
   logic [15:0]   m_cx;
   logic [15:0]   m_cy;
   logic [PW-1:0] m_cexp;
   logic [PW-1:0] m_cact;

   function automatic logic [CW-1:0] pat_val(input logic [PW-1:0] seed,
                                            input logic [PW-1:0] step,
                                            input int c, input int k);
      int v;
      v = int'(seed[c*CW +: CW]) + k * int'(step[c*CW +: CW]);
      return v[CW-1:0];
   endfunction

   function automatic logic [DW-1:0] mk_data(input logic [PW-1:0] seed,
                                            input logic [PW-1:0] step,
                                            input int k, input int bad_ch,
                                            input logic [CW-1:0] bad_val);
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      for (int c = 0; c < NC; c++) begin
         d[c*SW+LP +: CW] = (c == bad_ch) ? bad_val : pat_val(seed, step, c, k);
      end
      return d;
   endfunction

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic m_clear();
      m_in_frame = 1'b0;
      m_k = 0; m_x = 0; m_y = 0;
      m_seed = '0;
      m_pix = '0; m_frames = '0; m_mism = '0; m_flags = '0;
      m_capv = 1'b0; m_cx = '0; m_cy = '0; m_cexp = '0; m_cact = '0;
   endtask

   // Applies the inputs present at a rising edge to the model.
   task automatic m_beat();
      logic [PW-1:0] ev;
      logic [PW-1:0] av;
      bit            lastx;
      if (chk_clear) begin
         m_clear();
         return;
      end
      if (!(aclken && tvalid && tready)) return;
      m_pix = sat(m_pix);
      if (!m_in_frame && !tuser) begin
         m_flags[0] = 1'b1;
         return;
      end
      if (tuser) begin
         if (m_in_frame) m_flags[1] = 1'b1;
         m_in_frame = 1'b1;
         m_k = 0; m_x = 0; m_y = 0;
         m_seed = pat_seed;
      end
      for (int c = 0; c < NC; c++) begin
         ev[c*CW +: CW] = pat_val(m_seed, pat_step, c, m_k);
         av[c*CW +: CW] = tdata[c*SW+LP +: CW];
      end
      if (ev != av) begin
         m_mism = sat(m_mism);
         m_flags[4] = 1'b1;
         if (!m_capv) begin
            m_capv = 1'b1;
            m_cx = 16'(m_x); m_cy = 16'(m_y); m_cexp = ev; m_cact = av;
         end
      end
      lastx = (m_x == W - 1);
      if (tlast && !lastx) m_flags[2] = 1'b1;
      if (lastx && !tlast) m_flags[3] = 1'b1;
      if (lastx || tlast) begin
         m_x = 0;
         if (m_y == H - 1) begin
            m_in_frame = 1'b0;
            m_y = 0;
            if (lastx) m_frames = sat(m_frames);
         end else begin
            m_y = m_y + 1;
         end
      end else begin
         m_x = m_x + 1;
      end
      m_k = m_k + 1;
   endtask

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      cmp(name, got, want);
   endtask

   task automatic check_all();
      vectors++;
      cmp("pixel_count",    64'(pixel_count),    64'(m_pix));
      cmp("frame_count",    64'(frame_count),    64'(m_frames));
      cmp("mismatch_count", 64'(mismatch_count), 64'(m_mism));
      cmp("err_flags",      64'(err_flags),      64'(m_flags));
      cmp("first_err_x",    64'(first_err_x),    CAP_ON ? 64'(m_cx)   : 64'd0);
      cmp("first_err_y",    64'(first_err_y),    CAP_ON ? 64'(m_cy)   : 64'd0);
      cmp("first_err_exp",  64'(first_err_exp),  CAP_ON ? 64'(m_cexp) : 64'd0);
      cmp("first_err_act",  64'(first_err_act),  CAP_ON ? 64'(m_cact) : 64'd0);
   endtask

   // One clock: drive at the falling edge, model at the rising edge, check at
   // the next falling edge.
   task automatic cyc(input logic en, input logic v, input logic r, input logic u,
                      input logic l, input logic [DW-1:0] d, input logic clr);
      aclken = en; tvalid = v; tready = r; tuser = u; tlast = l; tdata = d; chk_clear = clr;
      @(posedge clk);
      m_beat();
      @(negedge clk);
      check_all();
   endtask

   task automatic beat(input int k, input logic u, input logic l);
      cyc(1'b1, 1'b1, 1'b1, u, l, mk_data(pat_seed, pat_step, k, -1, 8'h00), 1'b0);
   endtask

   task automatic bad_beat(input int k, input int ch, input logic [CW-1:0] val,
                           input logic u, input logic l);
      cyc(1'b1, 1'b1, 1'b1, u, l, mk_data(pat_seed, pat_step, k, ch, val), 1'b0);
   endtask

   task automatic clear_cyc();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      m_clear();
      @(negedge clk);
      check_all();
      aresetn = 1'b1;
   endtask

   initial begin
      int gk;
      aresetn = 1'b0; aclken = 1'b0; tvalid = 1'b0; tready = 1'b0;
      tuser = 1'b0; tlast = 1'b0; tdata = '0; chk_clear = 1'b0;
      pat_seed = 24'h302010;
      pat_step = 24'hFFFE01;
      m_clear();
      repeat (2) @(negedge clk);
      lit("reset pixel_count",    64'(pixel_count),    64'd0);
      lit("reset frame_count",    64'(frame_count),    64'd0);
      lit("reset mismatch_count", 64'(mismatch_count), 64'd0);
      lit("reset err_flags",      64'(err_flags),      64'd0);
      lit("reset first_err_exp",  64'(first_err_exp),  64'd0);
      aresetn = 1'b1;

      // clean frame
      for (int k = 0; k < 8; k++) beat(k, k == 0, (k % W) == W - 1);
      lit("clean frame_count", 64'(frame_count), 64'd1);
      lit("clean pixel_count", 64'(pixel_count), 64'd8);
      lit("clean err_flags",   64'(err_flags),   64'd0);

      // beats without tuser
      clear_cyc();
      for (int k = 0; k < 3; k++) beat(k, 1'b0, 1'b0);
      lit("nosof err_flags",      64'(err_flags),      64'h01);
      lit("nosof mismatch_count", 64'(mismatch_count), 64'd0);
      lit("nosof frame_count",    64'(frame_count),    64'd0);
      lit("nosof pixel_count",    64'(pixel_count),    64'd3);

      // early tlast on beat 2, beat 3 becomes (0,1)
      clear_cyc();
      beat(0, 1'b1, 1'b0); beat(1, 1'b0, 1'b0); beat(2, 1'b0, 1'b1);
      for (int k = 3; k < 7; k++) beat(k, 1'b0, k == 6);
      lit("eolearly err_flags",      64'(err_flags),      64'h04);
      lit("eolearly frame_count",    64'(frame_count),    64'd1);
      lit("eolearly mismatch_count", 64'(mismatch_count), 64'd0);

      // tlast missing on beat 3
      clear_cyc();
      for (int k = 0; k < 8; k++) beat(k, k == 0, k == 7);
      lit("eollate err_flags",   64'(err_flags),   64'h08);
      lit("eollate frame_count", 64'(frame_count), 64'd1);

      // channel 1 corrupted on beat 5
      clear_cyc();
      for (int k = 0; k < 8; k++) begin
         if (k == 5) bad_beat(k, 1, 8'h00, 1'b0, 1'b0);
         else        beat(k, k == 0, (k % W) == W - 1);
      end
      lit("data mismatch_count", 64'(mismatch_count), 64'd1);
      lit("data err_flags",      64'(err_flags),      64'h10);
      lit("data first_err_x",    64'(first_err_x),    CAP_ON ? 64'd1 : 64'd0);
      lit("data first_err_y",    64'(first_err_y),    CAP_ON ? 64'd1 : 64'd0);
      lit("data first_err_exp",  64'(first_err_exp),  CAP_ON ? 64'h2B1615 : 64'd0);
      lit("data first_err_act",  64'(first_err_act),  CAP_ON ? 64'h2B0015 : 64'd0);

      // back-pressure and clock-enable stalls mid-frame
      clear_cyc();
      for (int k = 0; k < 3; k++) beat(k, k == 0, 1'b0);
      repeat (10) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk_data(pat_seed, pat_step, 3, -1, 8'h00), 1'b0);
      lit("tready stall pixel_count", 64'(pixel_count), 64'd3);
      repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk_data(pat_seed, pat_step, 3, -1, 8'h00), 1'b0);
      lit("aclken stall pixel_count", 64'(pixel_count), 64'd3);
      for (int k = 3; k < 7; k++) beat(k, 1'b0, (k % W) == W - 1);
      repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, mk_data(pat_seed, pat_step, 7, -1, 8'h00), 1'b0);
      lit("pending frame_count", 64'(frame_count), 64'd0);
      beat(7, 1'b0, 1'b1);
      lit("stall frame_count", 64'(frame_count), 64'd1);
      lit("stall pixel_count", 64'(pixel_count), 64'd8);
      lit("stall err_flags",   64'(err_flags),   64'd0);

      // clear coincident with a beat after errors
      for (int k = 0; k < 2; k++) beat(k, 1'b0, 1'b0);
      beat(0, 1'b1, 1'b0);
      bad_beat(1, 0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk_data(pat_seed, pat_step, 2, -1, 8'h00), 1'b1);
      lit("clear pixel_count",    64'(pixel_count),    64'd0);
      lit("clear mismatch_count", 64'(mismatch_count), 64'd0);
      lit("clear err_flags",      64'(err_flags),      64'd0);
      lit("clear first_err_act",  64'(first_err_act),  64'd0);
      beat(3, 1'b0, 1'b0);
      lit("clear then wait_sof flags", 64'(err_flags), 64'h01);

      // tuser mid-frame restarts the frame
      clear_cyc();
      beat(0, 1'b1, 1'b0); beat(1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) beat(k, k == 0, (k % W) == W - 1);
      lit("sofearly err_flags",   64'(err_flags),   64'h02);
      lit("sofearly frame_count", 64'(frame_count), 64'd1);

      // tuser and tlast together: EOL check at x=0
      clear_cyc();
      beat(0, 1'b1, 1'b1);
      for (int k = 1; k < 5; k++) beat(k, 1'b0, k == 4);
      lit("sof+eol err_flags",   64'(err_flags),   64'h04);
      lit("sof+eol frame_count", 64'(frame_count), 64'd1);

      // reset mid-frame: next beat needs a fresh tuser
      beat(0, 1'b1, 1'b0); beat(1, 1'b0, 1'b0);
      do_reset();
      beat(2, 1'b0, 1'b0);
      lit("midreset err_flags",   64'(err_flags),   64'h01);
      lit("midreset pixel_count", 64'(pixel_count), 64'd1);

      // randomized traffic checked against the model every cycle
      gk = 0;
      for (int i = 0; i < 4000; i++) begin
         logic en, v, r, u, l, clr;
         int   badc;
         en   = ($urandom_range(7) != 0);
         v    = ($urandom_range(3) != 0);
         r    = ($urandom_range(3) != 0);
         u    = (gk == 0) ? ($urandom_range(15) != 0) : ($urandom_range(63) == 0);
         l    = ((gk % W) == W - 1) ? ($urandom_range(15) != 0) : ($urandom_range(47) == 0);
         badc = ($urandom_range(31) == 0) ? int'($urandom_range(NC - 1)) : -1;
         clr  = ($urandom_range(249) == 0);
         if ($urandom_range(599) == 0) begin
            pat_seed = PW'($urandom);
            pat_step = PW'($urandom);
            do_reset();
            gk = 0;
         end else begin
            if (clr) begin
               pat_seed = PW'($urandom);
               pat_step = PW'($urandom);
            end
            cyc(en, v, r, u, l, mk_data(pat_seed, pat_step, gk, badc, CW'($urandom)), clr);
            if (clr) gk = 0;
            else if (en && v && r) gk = u ? 1 : (gk + 1) % (W * H);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
